umem_arb: RTL and testbench

Two-port arbiter and access sequencer for the unified single-port data memory in the SimpRisc design. It shares the memory between the CPU load/store port and the AXI-side memory port. It performs byte-lane steering and load extension for CPU accesses, and window checking for AXI accesses. Every memory access is sequenced through a fixed three-cycle grant → access → response flow.

---
 rtl/umem_arb_if.sv | 37 +++
 rtl/umem_arb.sv | 157 +++++++++++++++
 tb/tb_umem_arb.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/umem_arb_if.sv
// Bus bundle for umem_arb: CPU load/store port, AXI-side port and the single-port memory.
// The arbiter connects through the slave modport; the requesters/memory side uses master.
interface umem_arb_if;
    logic        cpu_req, cpu_we;
    logic [2:0]  cpu_f3;
    logic [31:0] cpu_addr, cpu_wdata;
    logic        cpu_gnt, cpu_rvalid, cpu_err;
    logic [31:0] cpu_rdata;

    logic        axi_req, axi_we;
    logic [31:0] axi_addr, axi_wdata;
    logic        axi_gnt, axi_rvalid, axi_err;
    logic [31:0] axi_rdata;

    logic        mem_en, mem_we;
    logic [3:0]  mem_be;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_f3, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_rvalid, cpu_rdata, cpu_err,
        input  axi_req, axi_we, axi_addr, axi_wdata,
        output axi_gnt, axi_rvalid, axi_rdata, axi_err,
        output mem_en, mem_we, mem_be, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_f3, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_rvalid, cpu_rdata, cpu_err,
        output axi_req, axi_we, axi_addr, axi_wdata,
        input  axi_gnt, axi_rvalid, axi_rdata, axi_err,
        input  mem_en, mem_we, mem_be, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/umem_arb.sv
// Round-robin CPU/AXI arbiter for the unified data memory: grant -> access -> response.
// Optional macro UMEM_ARB_SIGNEXT_EN enables signed/unsigned load variants (f3 000/001 vs 100/101).
module umem_arb #(
    parameter logic [31:0] WIN_BASE = 32'hA0000100,
    parameter int          WIN_SIZE = 256
) (
    input logic       clk,
    input logic       rst,
    umem_arb_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [31:0] WSZ = 32'(WIN_SIZE);

    state_t      state;
    logic        last_cpu, own_axi, l_we, l_err, l_sx;
    logic [1:0]  l_sz, l_lane;

    logic        pick_cpu, pick_axi, cerr, aerr, s_we, s_err;
    logic [3:0]  cbe, s_be;
    logic [31:0] cwd, s_wd, s_addr, aoff;

    // last_cpu resets low, so the CPU wins the first tie
    assign pick_cpu = (state == IDLE) && !rst && bus.cpu_req && (!bus.axi_req || !last_cpu);
    assign pick_axi = (state == IDLE) && !rst && bus.axi_req && !pick_cpu;
    assign bus.cpu_gnt = pick_cpu;
    assign bus.axi_gnt = pick_axi;

    always_comb begin
        cerr = 1'b1;
        case (bus.cpu_f3)
`ifdef UMEM_ARB_SIGNEXT_EN
            3'b000:  cerr = 1'b0;
            3'b001:  cerr = bus.cpu_addr[0];
            3'b010:  cerr = |bus.cpu_addr[1:0];
            3'b100:  cerr = bus.cpu_we;
            3'b101:  cerr = bus.cpu_we | bus.cpu_addr[0];
            default: cerr = 1'b1;
`else
            3'b000:  cerr = 1'b0;
            3'b001:  cerr = bus.cpu_addr[0];
            3'b010:  cerr = |bus.cpu_addr[1:0];
            default: cerr = 1'b1;
`endif
        endcase
    end

    assign aoff = bus.axi_addr - WIN_BASE;
    assign aerr = (|bus.axi_addr[1:0]) || (aoff >= WSZ);

    always_comb begin
        cbe = 4'hF;
        cwd = bus.cpu_wdata;
        case (bus.cpu_f3[1:0])
            2'b00: begin
                cbe = 4'b0001 << bus.cpu_addr[1:0];
                cwd = {4{bus.cpu_wdata[7:0]}};
            end
            2'b01: begin
                cbe = bus.cpu_addr[1] ? 4'b1100 : 4'b0011;
                cwd = {2{bus.cpu_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    assign s_we   = pick_axi ? bus.axi_we    : bus.cpu_we;
    assign s_addr = pick_axi ? bus.axi_addr  : bus.cpu_addr;
    assign s_wd   = pick_axi ? bus.axi_wdata : cwd;
    assign s_be   = pick_axi ? 4'hF          : cbe;
    assign s_err  = pick_axi ? aerr          : cerr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            last_cpu       <= 1'b0;
            own_axi        <= 1'b0;
            l_we           <= 1'b0;
            l_err          <= 1'b0;
            l_sx           <= 1'b0;
            l_sz           <= 2'b00;
            l_lane         <= 2'b00;
            bus.mem_en     <= 1'b0;
            bus.mem_we     <= 1'b0;
            bus.mem_be     <= 4'h0;
            bus.mem_addr   <= '0;
            bus.mem_wdata  <= '0;
            bus.cpu_rvalid <= 1'b0;
            bus.cpu_err    <= 1'b0;
            bus.axi_rvalid <= 1'b0;
            bus.axi_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (pick_cpu || pick_axi) begin
                    state    <= ACCESS;
                    last_cpu <= pick_cpu;
                    own_axi  <= pick_axi;
                    l_we     <= s_we;
                    l_err    <= s_err;
                    l_sz     <= pick_axi ? 2'b10 : bus.cpu_f3[1:0];
`ifdef UMEM_ARB_SIGNEXT_EN
                    l_sx     <= pick_cpu && !bus.cpu_f3[2];
`else
                    l_sx     <= 1'b0;
`endif
                    l_lane        <= s_addr[1:0];
                    // memory strobes go out registered, so they appear in the ACCESS cycle
                    bus.mem_en    <= !s_err;
                    bus.mem_we    <= s_we && !s_err;
                    bus.mem_be    <= s_err ? 4'h0 : s_be;
                    bus.mem_addr  <= s_err ? 30'h0 : s_addr[31:2];
                    bus.mem_wdata <= (s_we && !s_err) ? s_wd : 32'h0;
                end
                ACCESS: begin
                    state          <= RESP;
                    bus.mem_en     <= 1'b0;
                    bus.mem_we     <= 1'b0;
                    bus.mem_be     <= 4'h0;
                    bus.mem_addr   <= '0;
                    bus.mem_wdata  <= '0;
                    bus.cpu_rvalid <= !own_axi;
                    bus.axi_rvalid <= own_axi;
                    bus.cpu_err    <= !own_axi && l_err;
                    bus.axi_err    <= own_axi && l_err;
                end
                RESP: begin
                    state          <= IDLE;
                    bus.cpu_rvalid <= 1'b0;
                    bus.axi_rvalid <= 1'b0;
                    bus.cpu_err    <= 1'b0;
                    bus.axi_err    <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // mem_rdata only arrives in the RESP cycle, so load formatting is combinational
    logic [7:0]  rbyte;
    logic [15:0] rhalf;
    logic [31:0] fmt;
    logic        rd_ok;

    always_comb begin
        rbyte = bus.mem_rdata[{l_lane, 3'b000} +: 8];
        rhalf = l_lane[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
        case (l_sz)
            2'b00:   fmt = {{24{l_sx & rbyte[7]}}, rbyte};
            2'b01:   fmt = {{16{l_sx & rhalf[15]}}, rhalf};
            default: fmt = bus.mem_rdata;
        endcase
    end

    assign rd_ok         = (state == RESP) && !rst && !l_we && !l_err;
    assign bus.cpu_rdata = (rd_ok && !own_axi) ? fmt : 32'h0;
    assign bus.axi_rdata = (rd_ok &&  own_axi) ? fmt : 32'h0;
endmodule

// File: tb/tb_umem_arb.sv
// Directed bench for umem_arb: reset, round-robin, lane steering, error paths, mid-access reset.
module tb_umem_arb;
    localparam logic [31:0] WB = 32'hA0000100;
`ifdef UMEM_ARB_SIGNEXT_EN
    localparam logic [31:0] LB_13   = 32'hFFFFFF80;
    localparam logic        F3_4ERR = 1'b0;
`else
    localparam logic [31:0] LB_13   = 32'h00000080;
    localparam logic        F3_4ERR = 1'b1;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    umem_arb_if bus();
    umem_arb #(.WIN_BASE(WB), .WIN_SIZE(256)) dut (.clk(clk), .rst(rst), .bus(bus));

    // memory model: read data appears the cycle after mem_en
    logic [31:0] ram [64] = '{default: 32'h0};
    always @(posedge clk) if (bus.mem_en) begin
        for (int i = 0; i < 4; i++)
            if (bus.mem_we && bus.mem_be[i]) ram[bus.mem_addr[5:0]][8*i +: 8] <= bus.mem_wdata[8*i +: 8];
        bus.mem_rdata <= ram[bus.mem_addr[5:0]];
    end

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // one full transaction on either port, starting at the next falling edge
    task automatic acc(input string nm, input logic axi, input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be,
                       input logic [31:0] mwd, input logic [31:0] rd, input logic err);
        @(negedge clk);
        if (axi) begin
            bus.axi_req = 1'b1; bus.axi_we = we; bus.axi_addr = a; bus.axi_wdata = wd;
        end else begin
            bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_f3 = f3; bus.cpu_addr = a; bus.cpu_wdata = wd;
        end
        #1;
        chk({nm, ".gnt"},       axi ? bus.axi_gnt : bus.cpu_gnt, 1);
        chk({nm, ".gnt_other"}, axi ? bus.cpu_gnt : bus.axi_gnt, 0);
        chk({nm, ".rvalid_idle"}, axi ? bus.axi_rvalid : bus.cpu_rvalid, 0);
        @(negedge clk);
        bus.cpu_req = 1'b0; bus.axi_req = 1'b0;
        #1;
        chk({nm, ".mem_en"},    bus.mem_en, !err);
        chk({nm, ".mem_we"},    bus.mem_we, we && !err);
        chk({nm, ".mem_be"},    bus.mem_be, err ? 4'h0 : be);
        chk({nm, ".mem_addr"},  bus.mem_addr, err ? 30'h0 : a[31:2]);
        chk({nm, ".mem_wdata"}, bus.mem_wdata, mwd);
        @(negedge clk);
        #1;
        chk({nm, ".rvalid"},       axi ? bus.axi_rvalid : bus.cpu_rvalid, 1);
        chk({nm, ".rvalid_other"}, axi ? bus.cpu_rvalid : bus.axi_rvalid, 0);
        chk({nm, ".rdata"},        axi ? bus.axi_rdata : bus.cpu_rdata, rd);
        chk({nm, ".err"},          axi ? bus.axi_err : bus.cpu_err, err);
        chk({nm, ".mem_en_resp"},  bus.mem_en, 0);
    endtask

    initial begin
        rst = 1'b1;
        bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_f3 = 3'b010; bus.cpu_addr = 0; bus.cpu_wdata = 0;
        bus.axi_req = 0; bus.axi_we = 0; bus.axi_addr = 0; bus.axi_wdata = 0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst.cpu_gnt", bus.cpu_gnt, 0);
        chk("rst.axi_gnt", bus.axi_gnt, 0);
        chk("rst.cpu_rvalid", bus.cpu_rvalid, 0);
        chk("rst.axi_rvalid", bus.axi_rvalid, 0);
        chk("rst.mem_en", bus.mem_en, 0);
        chk("rst.mem_be", bus.mem_be, 0);
        chk("rst.cpu_rdata", bus.cpu_rdata, 0);
        chk("rst.axi_err", bus.axi_err, 0);

        // both ports held: CPU first, then alternating every 3 cycles
        @(negedge clk);
        rst = 1'b0;
        bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_f3 = 3'b010; bus.cpu_addr = 32'h10;
        bus.axi_req = 1; bus.axi_we = 0; bus.axi_addr = WB;
        for (int k = 0; k < 12; k++) begin
            #1;
            chk($sformatf("rr.cpu_gnt[%0d]", k), bus.cpu_gnt, (k % 6) == 0);
            chk($sformatf("rr.axi_gnt[%0d]", k), bus.axi_gnt, (k % 6) == 3);
            @(negedge clk);
        end
        bus.cpu_req = 0; bus.axi_req = 0;

        //   name       axi we f3      addr          wdata         be     mem_wdata     rdata         err
        acc("st_w",     0, 1, 3'b010, 32'h10,       32'hDEADBEEF, 4'hF, 32'hDEADBEEF, 32'h0,        0);
        acc("ld_w",     0, 0, 3'b010, 32'h10,       32'h0,        4'hF, 32'h0,        32'hDEADBEEF, 0);
        acc("st_b",     0, 1, 3'b000, 32'h13,       32'h00000080, 4'h8, 32'h80808080, 32'h0,        0);
        acc("ld_b",     0, 0, 3'b000, 32'h13,       32'h0,        4'h8, 32'h0,        LB_13,        0);
        acc("ld_b1",    0, 0, 3'b100, 32'h11,       32'h0,        4'h2, 32'h0,
            F3_4ERR ? 32'h0 : 32'h000000BE, F3_4ERR);
        acc("ld_h_hi",  0, 0, 3'b001, 32'h12,       32'h0,        4'hC, 32'h0,
            F3_4ERR ? 32'h000080AD : 32'hFFFF80AD, 0);
        acc("ld_h_ua",  0, 0, 3'b001, 32'h5,        32'h0,        4'h0, 32'h0,        32'h0,        1);
        acc("f3_011",   0, 0, 3'b011, 32'h10,       32'h0,        4'h0, 32'h0,        32'h0,        1);
        acc("ld_w_ua",  0, 0, 3'b010, 32'h12,       32'h0,        4'h0, 32'h0,        32'h0,        1);
        acc("axi_wr",   1, 1, 3'b010, WB,           32'h12345678, 4'hF, 32'h12345678, 32'h0,        0);
        acc("axi_rd",   1, 0, 3'b010, WB,           32'h0,        4'hF, 32'h0,        32'h12345678, 0);
        acc("axi_oow",  1, 0, 3'b010, WB + 32'h1FC, 32'h0,        4'h0, 32'h0,        32'h0,        1);
        acc("axi_ua",   1, 1, 3'b010, 32'hA0000102, 32'h55AA55AA, 4'h0, 32'h0,        32'h0,        1);
        acc("axi_top",  1, 0, 3'b010, 32'hA00001FC, 32'h0,        4'hF, 32'h0,        32'h0,        0);
        acc("axi_low",  1, 0, 3'b010, 32'hA00000FC, 32'h0,        4'h0, 32'h0,        32'h0,        1);

        // reset during ACCESS drops the transaction; a fresh request is granted at once
        @(negedge clk);
        bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_f3 = 3'b010; bus.cpu_addr = 32'h10;
        #1 chk("rmid.gnt", bus.cpu_gnt, 1);
        @(negedge clk);
        bus.cpu_req = 0; rst = 1'b1;
        #1 chk("rmid.mem_en_access", bus.mem_en, 1);
        @(negedge clk);
        rst = 1'b0; bus.cpu_req = 1;
        #1;
        chk("rmid.rvalid", bus.cpu_rvalid, 0);
        chk("rmid.mem_en", bus.mem_en, 0);
        chk("rmid.err", bus.cpu_err, 0);
        chk("rmid.rdata", bus.cpu_rdata, 0);
        chk("rmid.regnt", bus.cpu_gnt, 1);
        @(negedge clk);
        bus.cpu_req = 0;
        #1 chk("rmid.mem_en2", bus.mem_en, 1);
        @(negedge clk);
        #1;
        chk("rmid.rvalid2", bus.cpu_rvalid, 1);
        chk("rmid.rdata2", bus.cpu_rdata, 32'h80ADBEEF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
